// File: rtl/gate_net_pipe.sv
// rtl/gate_net_pipe.sv - two-stage valid/ready gate network, WIDTH independent lanes
// Optional output-toggle counter built when GATE_NET_TOGGLE_CNT_EN is defined.
module gate_net_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y
`ifdef GATE_NET_TOGGLE_CNT_EN
  ,
  output logic [CNT_W-1:0] toggle_cnt,
  input  logic             cnt_clr
`endif
);

  if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
    $error("gate_net_pipe: WIDTH and CNT_W must be at least 1");
  end

  logic             s1_valid;
  logic [WIDTH-1:0] s1_t1;
  logic [WIDTH-1:0] s1_t2;
  logic [WIDTH-1:0] s1_t3;
  logic [1:0]       s1_mode;
  logic             s2_valid;
  logic             s1_adv;
  logic             s2_adv;
  logic [WIDTH-1:0] y_next;

  // A stage may load when it is empty or its content leaves this cycle.
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_t1    <= '0;
      s1_t2    <= '0;
      s1_t3    <= '0;
      s1_mode  <= 2'd0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_t1   <= ~(a & b);
        s1_t2   <= c & ~b & d;
        s1_t3   <= ~(e | f);
        s1_mode <= mode;
      end
    end
  end

  always_comb begin
    y_next = s1_t1;
    case (s1_mode)
      2'd0:    y_next = ~(s1_t1 & s1_t2 & s1_t3);
      2'd1:    y_next = s1_t1 | s1_t2 | s1_t3;
      2'd2:    y_next = s1_t1 ^ s1_t2 ^ s1_t3;
      default: y_next = s1_t1;
    endcase
  end

  // A bubble clears s2_valid but leaves y at its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      y        <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        y <= y_next;
      end
    end
  end

`ifdef GATE_NET_TOGGLE_CNT_EN
  logic [WIDTH-1:0] prev_y;
  logic             out_xfer;

  assign out_xfer = s2_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_y     <= '0;
      toggle_cnt <= '0;
    end else begin
      if (out_xfer) begin
        prev_y <= y;
      end
      if (cnt_clr) begin
        toggle_cnt <= '0;
      end else if (out_xfer && (y != prev_y) && (toggle_cnt != {CNT_W{1'b1}})) begin
        toggle_cnt <= toggle_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_gate_net_pipe.sv
// tb/tb_gate_net_pipe.sv - table-driven and scoreboard bench for gate_net_pipe
// Toggle-counter checks run when GATE_NET_TOGGLE_CNT_EN is defined.
module tb_gate_net_pipe;
  localparam int W = 4;
`ifdef GATE_NET_TOGGLE_CNT_EN
  localparam int CW = 2;
`else
  localparam int CW = 8;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b, c, d, e, f;
  logic [1:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
`ifdef GATE_NET_TOGGLE_CNT_EN
  logic [CW-1:0] toggle_cnt;
  logic          cnt_clr;
`endif

  always #5 clk = ~clk;

  gate_net_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .y(y)
`ifdef GATE_NET_TOGGLE_CNT_EN
    , .toggle_cnt(toggle_cnt), .cnt_clr(cnt_clr)
`endif
  );

  typedef struct {
    logic [W-1:0] a, b, c, d, e, f;
    logic [1:0]   mode;
    logic [W-1:0] exp;
  } vec_t;

  vec_t         tbl[8];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur_exp;
  int           n_cmp = 0;
  int           n_bad = 0;
  bit           acc, xfer;

  function automatic logic [W-1:0] model(input logic [W-1:0] ma, mb, mc, md, me, mf,
                                         input logic [1:0] mm);
    logic [W-1:0] t1, t2, t3;
    t1 = ~(ma & mb);
    t2 = mc & ~mb & md;
    t3 = ~(me | mf);
    case (mm)
      2'd0:    return ~(t1 & t2 & t3);
      2'd1:    return t1 | t2 | t3;
      2'd2:    return t1 ^ t2 ^ t3;
      default: return t1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input vec_t v);
    a = v.a; b = v.b; c = v.c; d = v.d; e = v.e; f = v.f;
    mode = v.mode;
    cur_exp = v.exp;
  endtask

  // Called just after a falling edge; samples, runs the scoreboard, advances one cycle.
  task automatic step();
    #1;
    acc  = in_valid && in_ready;
    xfer = out_valid && out_ready;
    if (xfer) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got y=%0h expected no output", y);
      end else begin
        chk("sb_y", 32'(y), 32'(exp_q.pop_front()));
      end
    end
    if (acc) exp_q.push_back(cur_exp);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) step();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic latency_test(input vec_t v);
    set_vec(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    chk("lat_accept", 32'(acc), 32'd1);
    in_valid = 1'b0;
    #1 chk("lat_cycle1_ov", 32'(out_valid), 32'd0);
    step();
    #1 chk("lat_cycle2_ov", 32'(out_valid), 32'd1);
    step();
    chk("lat_xfer", 32'(xfer), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    tbl[0] = '{4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 2'd0, 4'hF};
    tbl[1] = '{4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 2'd0, 4'h0};
    tbl[2] = '{4'hA, 4'h6, 4'hF, 4'hF, 4'h0, 4'h1, 2'd1, 4'hF};
    tbl[3] = '{4'hA, 4'h6, 4'hF, 4'hF, 4'h0, 4'h1, 2'd2, 4'hA};
    tbl[4] = '{4'hA, 4'h6, 4'hF, 4'hF, 4'h0, 4'h1, 2'd3, 4'hD};
    tbl[5] = '{4'hA, 4'h6, 4'hF, 4'hF, 4'h0, 4'h1, 2'd0, 4'h7};
    tbl[6] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 2'd3, 4'h0};
    tbl[7] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 2'd1, 4'hF};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c = '0; d = '0; e = '0; f = '0; mode = 2'd0; cur_exp = '0;
`ifdef GATE_NET_TOGGLE_CNT_EN
    cnt_clr = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    #1 chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    rst = 1'b0;
    #1 chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    latency_test(tbl[0]);

    // Back-to-back: results on consecutive cycles.
    set_vec(tbl[1]); in_valid = 1'b1; step();
    chk("b2b_acc0", 32'(acc), 32'd1);
    set_vec(tbl[0]); step();
    chk("b2b_acc1", 32'(acc), 32'd1);
    in_valid = 1'b0;
    step(); chk("b2b_xfer0", 32'(xfer), 32'd1);
    step(); chk("b2b_xfer1", 32'(xfer), 32'd1);

    for (int i = 2; i < 8; i++) begin
      set_vec(tbl[i]);
      in_valid = 1'b1;
      step();
      chk("tbl_acc", 32'(acc), 32'd1);
    end
    drain();

    // Backpressure with three offered vectors.
    out_ready = 1'b0;
    n_acc = 0;
    set_vec(tbl[2]); in_valid = 1'b1; step(); if (acc) n_acc++;
    set_vec(tbl[3]); step(); if (acc) n_acc++;
    set_vec(tbl[4]); step();
    chk("bp_third_acc", 32'(acc), 32'd0);
    chk("bp_n_acc", 32'(n_acc), 32'd2);
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_y_hold", 32'(y), 32'(tbl[2].exp));
      chk("bp_ov_hold", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 5 && !acc; k++) step();
    chk("bp_third_taken", 32'(acc), 32'd1);
    drain();

    // Asynchronous reset with both stages full.
    out_ready = 1'b0;
    set_vec(tbl[0]); in_valid = 1'b1;
    step(); step();
    in_valid = 1'b0;
    #1 chk("mid_full_ov", 32'(out_valid), 32'd1);
    #1 rst = 1'b1;
    #1 chk("mid_rst_ov", 32'(out_valid), 32'd0);
    chk("mid_rst_y", 32'(y), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    latency_test(tbl[0]);

    // Random traffic with random stalls.
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom); b = W'($urandom); c = W'($urandom);
      d = W'($urandom); e = W'($urandom); f = W'($urandom);
      mode = 2'($urandom_range(0, 3));
      cur_exp = model(a, b, c, d, e, f, mode);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

`ifdef GATE_NET_TOGGLE_CNT_EN
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    exp_q.delete();
    chk("tog_rst", 32'(toggle_cnt), 32'd0);
    begin
      int seq_y[6] = '{1, 1, 0, 1, 0, 1};
      int seq_c[6] = '{1, 1, 2, 3, 3, 3};
      for (int i = 0; i < 6; i++) begin
        set_vec(seq_y[i] != 0 ? tbl[0] : tbl[1]);
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        chk("tog_cnt", 32'(toggle_cnt), 32'(seq_c[i]));
      end
    end
    set_vec(tbl[1]); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("tog_clr_xfer", 32'(xfer), 32'd1);
    chk("tog_clr", 32'(toggle_cnt), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
